ex_stage: RTL and testbench

- Execute stage of the MIPS32 pipeline, fed directly by the id_ex pipeline register.
- Performs single-cycle logic, shift, add/sub and compare ops combinationally; forwards its result to ex_mem.
- Contains an iterative 32-cycle signed/unsigned divider that writes HI/LO.
- While a divide is in progress it raises a stall request to the pipeline controller.

---
 rtl/ex_stage_pkg.sv | 35 +++
 rtl/ex_div.sv | 98 +++++++++
 rtl/ex_stage.sv | 71 +++++++
 tb/tb_ex_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants for the MIPS32 execute stage: ALU op codes, widths and
// the divider state encoding.
package ex_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int ALUOP_W    = 8;
    localparam int REG_ADDR_W = 5;
    localparam int DIV_CYCLES = 32;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'h00;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'h25;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'h24;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'h26;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'h27;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'h7C;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'h02;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'h03;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP = 8'h21;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP = 8'h23;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP  = 8'h2A;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP = 8'h2B;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'h1A;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider: one quotient bit per cycle on a 64-bit
// remainder:quotient register, with sign correction applied on the way out.
module ex_div
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic              annul,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              ready,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    div_state_t          state_q, state_d;
    logic [2*DATA_W-1:0] rq_q, rq_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W:0]     rem_diff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            rq_q      <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rq_q      <= rq_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rq_d      = rq_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        // Partial remainder shifted left by one, pulling in the next dividend bit.
        rem_sh    = rq_q[2*DATA_W-1:DATA_W-1];
        rem_diff  = rem_sh - {1'b0, divisor_q};

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DIV_DONE;
                        rq_d    = {dividend, 32'hFFFF_FFFF};
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                    end else begin
                        state_d   = DIV_BUSY;
                        rq_d      = {32'd0, neg_if(dividend, is_signed & dividend[DATA_W-1])};
                        divisor_d = neg_if(divisor, is_signed & divisor[DATA_W-1]);
                        cnt_d     = '0;
                        qneg_d    = is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        rneg_d    = is_signed & dividend[DATA_W-1];
                    end
                end
            end
            DIV_BUSY: begin
                if (!rem_diff[DATA_W]) begin
                    rq_d = {rem_diff[DATA_W-1:0], rq_q[DATA_W-2:0], 1'b1};
                end else begin
                    rq_d = {rq_q[2*DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_CYCLES - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase

        if (annul) begin
            state_d = DIV_IDLE;
        end
    end

    assign ready     = (state_q == DIV_DONE);
    assign quotient  = neg_if(rq_q[DATA_W-1:0], qneg_q);
    assign remainder = neg_if(rq_q[2*DATA_W-1:DATA_W], rneg_q);

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: combinational ALU, multi-cycle divider feeding HI/LO,
// and the stall request that holds the front of the pipe during a divide.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ALUOP_W-1:0]    ex_aluOp,
    input  logic [DATA_W-1:0]     ex_opNum1,
    input  logic [DATA_W-1:0]     ex_opNum2,
    input  logic [REG_ADDR_W-1:0] ex_writeAddr,
    input  logic                  ex_writeReg,
    output logic [REG_ADDR_W-1:0] mem_writeAddr,
    output logic                  mem_writeReg,
    output logic [DATA_W-1:0]     mem_writeData,
    output logic                  mem_hiloWrite,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  stallReq
);

    logic              is_div;
    logic              div_ready;
    logic [DATA_W-1:0] div_quot;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] alu_result;

    assign is_div = (ex_aluOp == EXE_DIV_OP) || (ex_aluOp == EXE_DIVU_OP);

    ex_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div & ~flush),
        .is_signed (ex_aluOp == EXE_DIV_OP),
        .annul     (flush),
        .dividend  (ex_opNum1),
        .divisor   (ex_opNum2),
        .ready     (div_ready),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    always_comb begin
        alu_result = '0;
        case (ex_aluOp)
            EXE_OR_OP:   alu_result = ex_opNum1 | ex_opNum2;
            EXE_AND_OP:  alu_result = ex_opNum1 & ex_opNum2;
            EXE_XOR_OP:  alu_result = ex_opNum1 ^ ex_opNum2;
            EXE_NOR_OP:  alu_result = ~(ex_opNum1 | ex_opNum2);
            EXE_SLL_OP:  alu_result = ex_opNum2 << ex_opNum1[4:0];
            EXE_SRL_OP:  alu_result = ex_opNum2 >> ex_opNum1[4:0];
            EXE_SRA_OP:  alu_result = $signed(ex_opNum2) >>> ex_opNum1[4:0];
            EXE_ADDU_OP: alu_result = ex_opNum1 + ex_opNum2;
            EXE_SUBU_OP: alu_result = ex_opNum1 - ex_opNum2;
            EXE_SLT_OP:  alu_result = {31'd0, $signed(ex_opNum1) < $signed(ex_opNum2)};
            EXE_SLTU_OP: alu_result = {31'd0, ex_opNum1 < ex_opNum2};
            default:     alu_result = '0;
        endcase
    end

    // Every output is forced low while reset is held, independent of the clock.
    assign mem_writeAddr = rst ? ex_writeAddr : '0;
    assign mem_writeReg  = rst & ex_writeReg & ~flush;
    assign mem_writeData = rst ? alu_result : '0;
    assign mem_hiloWrite = rst & div_ready & ~flush;
    assign mem_hi        = rst ? div_rem : '0;
    assign mem_lo        = rst ? div_quot : '0;
    assign stallReq      = rst & is_div & ~div_ready;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against a plain-arithmetic model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [7:0]  aluop;
    logic [31:0] op1, op2;
    logic [4:0]  waddr;
    logic        wreg;
    logic [4:0]  mem_writeAddr;
    logic        mem_writeReg;
    logic [31:0] mem_writeData;
    logic        mem_hiloWrite;
    logic [31:0] mem_hi, mem_lo;
    logic        stallReq;

    int checks = 0;
    int errors = 0;

    logic [7:0] comb_ops [13] = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03,
                                  8'h21, 8'h23, 8'h2A, 8'h2B, 8'h00, 8'h55};

    ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ex_aluOp      (aluop),
        .ex_opNum1     (op1),
        .ex_opNum2     (op2),
        .ex_writeAddr  (waddr),
        .ex_writeReg   (wreg),
        .mem_writeAddr (mem_writeAddr),
        .mem_writeReg  (mem_writeReg),
        .mem_writeData (mem_writeData),
        .mem_hiloWrite (mem_hiloWrite),
        .mem_hi        (mem_hi),
        .mem_lo        (mem_lo),
        .stallReq      (stallReq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU: value semantics from the instruction definitions.
    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sb, d, q;
        int     sh;
        ua = longint'(a);
        ub = longint'(b);
        sb = longint'(int'(b));
        sh = int'(a[4:0]);
        d  = longint'(1) << sh;
        case (op)
            8'h25: return a | b;
            8'h24: return a & b;
            8'h26: return a ^ b;
            8'h27: return ~(a | b);
            8'h7C: return 32'(ub * d);
            8'h02: return 32'(ub / d);
            8'h03: begin
                q = sb / d;
                if (sb < 0 && (sb % d) != 0) q = q - 1;
                return 32'(q);
            end
            8'h21: return 32'(ua + ub);
            8'h23: return 32'(ua - ub);
            8'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            8'h2B: return (ua < ub) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint x, y;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (op == 8'h1A) begin
                x = longint'(int'(a));
                y = longint'(int'(b));
            end else begin
                x = longint'(a);
                y = longint'(b);
            end
            q = 32'(x / y);
            r = 32'(x % y);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] ad, input logic w, input logic f);
        aluop = op; op1 = a; op2 = b; waddr = ad; wreg = w; flush = f;
    endtask

    task automatic run_comb(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] ad, input logic w, input logic f);
        @(posedge clk); #1;
        drive(op, a, b, ad, w, f);
        @(negedge clk);
        $display("comb op=%h a=%h b=%h flush=%0d -> data=%h", op, a, b, f, mem_writeData);
        chk("writeData", mem_writeData, ref_alu(op, a, b));
        chk("writeAddr", 32'(mem_writeAddr), 32'(ad));
        chk("writeReg", 32'(mem_writeReg), 32'(w & ~f));
        chk("comb_stall", 32'(stallReq), 32'd0);
        chk("comb_hilo", 32'(mem_hiloWrite), 32'd0);
    endtask

    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        int st;
        logic early;
        ref_div(op, a, b, q, r);
        @(posedge clk); #1;
        drive(op, a, b, 5'($urandom_range(1, 31)), 1'b1, 1'b0);
        st = 0;
        early = 1'b0;
        @(negedge clk);
        while (stallReq === 1'b1 && st < 40) begin
            st++;
            if (mem_hiloWrite !== 1'b0) early = 1'b1;
            @(negedge clk);
        end
        $display("div op=%h a=%h b=%h stalls=%0d -> lo=%h hi=%h", op, a, b, st, mem_lo, mem_hi);
        chk("div_stalls", 32'(st), (b == 32'd0) ? 32'd1 : 32'd33);
        chk("div_early_hilo", 32'(early), 32'd0);
        chk("div_hilo", 32'(mem_hiloWrite), 32'd1);
        chk("div_lo", mem_lo, q);
        chk("div_hi", mem_hi, r);
    endtask

    initial begin
        logic seen;
        rst = 1'b0;
        drive(8'h25, 32'h1234_5678, 32'h0000_00FF, 5'd5, 1'b1, 1'b0);
        #1;
        $display("reset: data=%h addr=%h wreg=%0d", mem_writeData, mem_writeAddr, mem_writeReg);
        chk("rst_data", mem_writeData, 32'd0);
        chk("rst_addr", 32'(mem_writeAddr), 32'd0);
        chk("rst_wreg", 32'(mem_writeReg), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_comb(8'h25, 32'h0F0F_0000, 32'h0000_00FF, 5'd5, 1'b1, 1'b0);
        run_comb(8'h21, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 1'b1, 1'b0);
        chk("addu_const", mem_writeData, 32'h0000_0001);
        run_comb(8'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b1, 1'b0);
        chk("slt_const", mem_writeData, 32'd1);
        run_comb(8'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b1, 1'b0);
        chk("sltu_const", mem_writeData, 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_comb(comb_ops[$urandom_range(0, 12)], $urandom, $urandom,
                     5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        run_div(8'h1B, 32'd100, 32'd7);
        @(posedge clk); #1;
        drive(8'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("hilo_one_cycle", 32'(mem_hiloWrite), 32'd0);

        run_div(8'h1A, 32'hFFFF_FFF9, 32'd2);
        run_div(8'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(8'h1B, 32'd9, 32'd0);
        for (int i = 0; i < 6; i++) begin
            run_div(($urandom_range(0, 1) == 0) ? 8'h1A : 8'h1B, $urandom, $urandom_range(0, 3) == 0 ? 32'(-$urandom_range(1, 50)) : $urandom);
        end

        // Flush during BUSY, then confirm no HI/LO write and a clean restart.
        @(posedge clk); #1;
        drive(8'h1B, 32'd100, 32'd7, 5'd4, 1'b1, 1'b0);
        repeat (11) @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wreg", 32'(mem_writeReg), 32'd0);
        chk("flush_hilo", 32'(mem_hiloWrite), 32'd0);
        @(posedge clk); #1;
        drive(8'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_hiloWrite !== 1'b0) seen = 1'b1;
        end
        $display("flush: hilo seen afterwards=%0d", seen);
        chk("flush_no_hilo", 32'(seen), 32'd0);
        run_div(8'h1B, 32'd100, 32'd7);

        // Asynchronous reset between clock edges during BUSY.
        @(posedge clk); #1;
        drive(8'h1B, 32'd100, 32'd7, 5'd9, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        $display("async rst: stall=%0d addr=%h lo=%h hi=%h", stallReq, mem_writeAddr, mem_lo, mem_hi);
        chk("arst_stall", 32'(stallReq), 32'd0);
        chk("arst_addr", 32'(mem_writeAddr), 32'd0);
        chk("arst_wreg", 32'(mem_writeReg), 32'd0);
        chk("arst_hilo", 32'(mem_hiloWrite), 32'd0);
        chk("arst_lo", mem_lo, 32'd0);
        chk("arst_hi", mem_hi, 32'd0);
        drive(8'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run_div(8'h1B, 32'd100, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
